// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer burst reader.
//   pixel_t      : 24-bit RGB pixel
//   fifo_entry_t : one pixel FIFO entry {sof, pixel}
//   rd_state_t   : Avalon read-host state
package vga_pkg;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        logic   sof;
        pixel_t pixel;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2
    } rd_state_t;

    localparam int unsigned AVM_BURST_W = 6;
    localparam int unsigned ENTRY_W     = $bits(fifo_entry_t);

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever empty=0,
// and the next entry is visible the cycle after a pop.
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read
// side, empty/full flags, count = number of stored entries.
// A push while full and a pop while empty are ignored.
module pixel_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array, no reset needed: reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vga_burst_reader.sv
// Avalon-MM burst-read host that streams the framebuffer out of SDRAM into a
// pixel FIFO and replays the frame continuously.
// Ports:
//   clk, rst (async, active-high), enable (fetch frames while high)
//   avm_* : Avalon-MM read host (address/read/burstcount out,
//           readdata/readdatavalid/waitrequest in, write side tied off)
//   pix_valid/pix_ready/pix_data/pix_sof : pixel stream to the timing generator
//   overrun : sticky error, readdatavalid outside RECV or push into full FIFO
module vga_burst_reader
    import vga_pkg::*;
#(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned BURST      = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [31:0]            avm_address,
    output logic                   avm_read,
    output logic [AVM_BURST_W-1:0] avm_burstcount,
    output logic                   avm_write,
    output logic [3:0]             avm_byteenable,
    output logic [31:0]            avm_writedata,
    input  logic [31:0]            avm_readdata,
    input  logic                   avm_readdatavalid,
    input  logic                   avm_waitrequest,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [23:0]            pix_data,
    output logic                   pix_sof,
    output logic                   overrun
);

    localparam int unsigned NPIX   = HDISP * VDISP;
    localparam int unsigned IDX_W  = $clog2(NPIX);
    localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    if ((NPIX % BURST) != 0) begin : g_chk_burst
        $error("HDISP*VDISP must be a multiple of BURST");
    end
    if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < 2 * BURST)) begin : g_chk_fifo
        $error("FIFO_DEPTH must be a power of 2 and at least 2*BURST");
    end
    if (BURST >= (1 << AVM_BURST_W)) begin : g_chk_bcnt
        $error("BURST does not fit in avm_burstcount");
    end

    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [31:0]        idx_sum;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               last_beat;
    logic               space_ok;
    logic               overrun_q;

    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;

    logic               unused_rdata;

    assign unused_rdata = ^avm_readdata[31:24];

    // Room for a whole burst is reserved before the request goes out
    assign space_ok  = (32'(fifo_count) + BURST) <= FIFO_DEPTH;
    assign last_beat = (beat_cnt == BEAT_W'(BURST - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a read held in REQ cannot be withdrawn, so enable only gates IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && space_ok)                state_nxt = REQ;
            REQ:     if (!avm_waitrequest)                  state_nxt = RECV;
            RECV:    if (avm_readdatavalid && last_beat)    state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    // Output and datapath decode
    always_comb begin
        avm_read       = 1'b0;
        avm_burstcount = '0;
        avm_address    = BASE_ADDR + (32'(word_idx) << 2);
        fifo_push      = 1'b0;
        push_entry     = '0;
        idx_sum        = 32'(word_idx) + BURST;
        next_idx       = (idx_sum >= NPIX) ? '0 : IDX_W'(idx_sum);

        if (state == REQ) begin
            avm_read       = 1'b1;
            avm_burstcount = AVM_BURST_W'(BURST);
        end
        if (state == RECV) begin
            fifo_push = avm_readdatavalid;
        end
        push_entry.sof   = (word_idx == '0) && (beat_cnt == '0);
        push_entry.pixel = avm_readdata[23:0];
    end

    // Word/beat counters and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx  <= '0;
            beat_cnt  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (fifo_push) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    word_idx <= next_idx;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if ((avm_readdatavalid && (state != RECV)) || (fifo_push && fifo_full)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pix_ready),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign pix_valid      = ~fifo_empty;
    assign pix_data       = head_entry.pixel;
    assign pix_sof        = head_entry.sof;
    assign overrun        = overrun_q;

    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_writedata  = 32'h0;

endmodule
